// File: rtl/mips_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : mips_imem_loader
//  Purpose  : Boot-time instruction-memory loader for MIPS_single_cycle.
//             Receives a framed big-endian byte stream made of a header word
//             (16'hB007 magic, 16-bit word count), the program words and an
//             XOR checksum word. Each program word is written into
//             instruction memory at consecutive word addresses. The core is
//             held in reset until the image has been loaded and verified.
//  Ports    : clk          - rising-edge clock
//             rst          - asynchronous active-low reset
//             start        - one-cycle load request (ignored while busy)
//             rx_data      - stream byte
//             rx_valid     - rx_data valid
//             rx_ready     - byte accepted when rx_valid && rx_ready
//             imem_we      - one-cycle write strobe per word
//             imem_addr    - word address (registered)
//             imem_wdata   - word to write (registered)
//             core_rst     - active-low reset driven to the core
//             busy         - load in progress
//             done         - image loaded and verified
//             error        - bad magic, oversize count or checksum mismatch
//             words_loaded - payload words written so far
//  Revision : 1.0 - initial release
// ============================================================================
module mips_imem_loader #(
   parameter int INST_MEM_DEPTH = 256,
   parameter int width          = 32,
   localparam int AW            = $clog2(INST_MEM_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             rx_ready,
   output logic             imem_we,
   output logic [AW-1:0]    imem_addr,
   output logic [width-1:0] imem_wdata,
   output logic             core_rst,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [15:0]      words_loaded
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR   = 3'd1,
      LOAD  = 3'd2,
      CSUM  = 3'd3,
      DONE  = 3'd4,
      ERROR = 3'd5
   } state_t;

   localparam logic [15:0] MAGIC     = 16'hB007;
   localparam logic [16:0] MAX_WORDS = 17'(INST_MEM_DEPTH);

   state_t      state;
   logic [1:0]  byte_cnt;     // position of the next byte within its word
   logic [23:0] shreg;        // first three bytes of the word being assembled
   logic [31:0] csum_acc;     // XOR of all payload words
   logic [15:0] word_count;   // payload length taken from the header

   logic        accept;
   logic        last_byte;
   logic [31:0] word;

   // Decoded from the state register only, so there is no path from rx_valid.
   assign rx_ready  = (state == HDR) || (state == LOAD) || (state == CSUM);
   assign accept    = rx_valid && rx_ready;
   assign last_byte = (byte_cnt == 2'd3);
   // Big-endian: the byte completing the word lands in bits 7:0.
   assign word      = {shreg, rx_data};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         byte_cnt     <= 2'd0;
         shreg        <= 24'd0;
         csum_acc     <= 32'd0;
         word_count   <= 16'd0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         core_rst     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= 16'd0;
      end else begin
         imem_we <= 1'b0;

         // Byte alignment only advances on an actual transfer, so rx_valid
         // bubbles stall assembly without slipping a byte.
         if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= {shreg[15:0], rx_data};
         end

         case (state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  state        <= HDR;
                  byte_cnt     <= 2'd0;
                  csum_acc     <= 32'd0;
                  imem_addr    <= '0;
                  core_rst     <= 1'b0;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  error        <= 1'b0;
                  words_loaded <= 16'd0;
               end
            end

            HDR: begin
               if (accept && last_byte) begin
                  word_count <= word[15:0];
                  // Oversize counts are rejected here so imem_addr can
                  // never run past the end of the memory.
                  if ((word[31:16] != MAGIC) || ({1'b0, word[15:0]} > MAX_WORDS)) begin
                     state <= ERROR;
                     error <= 1'b1;
                     busy  <= 1'b0;
                  end else if (word[15:0] == 16'd0) begin
                     state <= CSUM;
                  end else begin
                     state     <= LOAD;
                     imem_addr <= '0;
                  end
               end
            end

            LOAD: begin
               if (accept && last_byte) begin
                  imem_we      <= 1'b1;
                  imem_wdata   <= word;
                  // words_loaded doubles as the address counter: it equals
                  // the index of the word being written.
                  imem_addr    <= words_loaded[AW-1:0];
                  words_loaded <= words_loaded + 16'd1;
                  csum_acc     <= csum_acc ^ word;
                  if ((words_loaded + 16'd1) == word_count) begin
                     state <= CSUM;
                  end
               end
            end

            CSUM: begin
               if (accept && last_byte) begin
                  busy <= 1'b0;
                  if (word == csum_acc) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     core_rst <= 1'b1;
                  end else begin
                     state <= ERROR;
                     error <= 1'b1;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
